commit_unit: RTL and testbench

In-order retirement stage of the out-of-order core. It reads the reorder-buffer entry at the head each cycle and commits completed entries in order: architectural register writeback, store release to the load/store queue, mispredict recovery and halt. It drives the ROB's head-advance and restore inputs, and it is the only consumer of the ROB commit read port.

---
 rtl/commit_if.sv | 43 ++++
 rtl/commit_unit.sv | 145 ++++++++++++++
 tb/tb_commit_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_if.sv
// Commit-stage bundle between the reorder buffer / LSQ / rename side and commit_unit.
// Signal names keep the ROB-facing _i/_o suffixes as seen from commit_unit.
interface commit_if #(
    parameter int ROBsize = 16
);
    localparam int addrSize = $clog2(ROBsize);

    logic [78:0]       commitReadData_i;
    logic [addrSize:0] head_i;
    logic              storeAck_i;

    logic              updateHead_o;
    logic              needToRestore_o;
    logic              redirectValid_o;
    logic [63:0]       redirectPc_o;
    logic              rfWriteEn_o;
    logic [4:0]        rfWriteAddr_o;
    logic [63:0]       rfWriteData_o;
    logic              renameClearEn_o;
    logic [addrSize:0] renameClearTag_o;
    logic              storeReq_o;
    logic [addrSize:0] storeTag_o;
    logic              halted_o;
    logic [31:0]       retireCount_o;

    // master: the commit unit itself
    modport master (
        input  commitReadData_i, head_i, storeAck_i,
        output updateHead_o, needToRestore_o, redirectValid_o, redirectPc_o,
               rfWriteEn_o, rfWriteAddr_o, rfWriteData_o,
               renameClearEn_o, renameClearTag_o,
               storeReq_o, storeTag_o, halted_o, retireCount_o
    );

    // slave: ROB, register file, rename table and LSQ side
    modport slave (
        output commitReadData_i, head_i, storeAck_i,
        input  updateHead_o, needToRestore_o, redirectValid_o, redirectPc_o,
               rfWriteEn_o, rfWriteAddr_o, rfWriteData_o,
               renameClearEn_o, renameClearTag_o,
               storeReq_o, storeTag_o, halted_o, retireCount_o
    );
endinterface

// File: rtl/commit_unit.sv
// In-order retirement of the ROB head: register writeback, store release,
// mispredict recovery and halt.
module commit_unit #(
    parameter int ROBsize = 16
) (
    input  logic     clk_i,
    input  logic     reset_i,
    commit_if.master cif
);
    localparam int addrSize = $clog2(ROBsize);

    typedef enum logic [1:0] {
        COMMIT,
        STORE_WAIT,
        RESTORE,
        HALTED
    } state_e;

    state_e            state_q, state_d;
    logic [63:0]       redirect_pc_q, redirect_pc_d;
    logic              store_req_q, store_req_d;
    logic [addrSize:0] store_tag_q, store_tag_d;
    logic              restore_q, restore_d;
    logic              halted_q, halted_d;
    logic [31:0]       retire_cnt_q, retire_cnt_d;

    logic              pop;
    logic              wr_en;

    // Head entry fields; bits [78:74] are reserved and deliberately unused.
    logic [63:0]       ent_value;
    logic              ent_done;
    logic [4:0]        ent_dest;
    logic              ent_regwrite;
    logic              ent_store;
    logic              ent_mispredict;
    logic              ent_halt;

    assign ent_value      = cif.commitReadData_i[63:0];
    assign ent_done       = cif.commitReadData_i[64];
    assign ent_dest       = cif.commitReadData_i[69:65];
    assign ent_regwrite   = cif.commitReadData_i[70];
    assign ent_store      = cif.commitReadData_i[71];
    assign ent_mispredict = cif.commitReadData_i[72];
    assign ent_halt       = cif.commitReadData_i[73];

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        store_req_d   = store_req_q;
        store_tag_d   = store_tag_q;
        restore_d     = 1'b0;
        halted_d      = halted_q;
        retire_cnt_d  = retire_cnt_q;
        pop           = 1'b0;
        wr_en         = 1'b0;

        unique case (state_q)
            COMMIT: begin
                if (ent_done) begin
                    // halt outranks store, store outranks mispredict
                    if (ent_halt) begin
                        pop          = 1'b1;
                        retire_cnt_d = retire_cnt_q + 32'd1;
                        halted_d     = 1'b1;
                        state_d      = HALTED;
                    end else if (ent_store) begin
                        store_req_d  = 1'b1;
                        store_tag_d  = cif.head_i;
                        state_d      = STORE_WAIT;
                    end else begin
                        pop          = 1'b1;
                        retire_cnt_d = retire_cnt_q + 32'd1;
                        wr_en        = ent_regwrite && (ent_dest != 5'd0);
                        if (ent_mispredict) begin
                            redirect_pc_d = ent_value;
                            restore_d     = 1'b1;
                            state_d       = RESTORE;
                        end
                    end
                end
            end
            STORE_WAIT: begin
                if (cif.storeAck_i) begin
                    pop          = 1'b1;
                    retire_cnt_d = retire_cnt_q + 32'd1;
                    store_req_d  = 1'b0;
                    store_tag_d  = '0;
                    state_d      = COMMIT;
                end
            end
            RESTORE: begin
                // The head seen here is on the wrong path and is flushed, never committed.
                state_d = COMMIT;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = COMMIT;
            end
        endcase

        // Combinational outputs read as zero while reset is held.
        if (!reset_i) begin
            pop   = 1'b0;
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= COMMIT;
            redirect_pc_q <= '0;
            store_req_q   <= 1'b0;
            store_tag_q   <= '0;
            restore_q     <= 1'b0;
            halted_q      <= 1'b0;
            retire_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            store_req_q   <= store_req_d;
            store_tag_q   <= store_tag_d;
            restore_q     <= restore_d;
            halted_q      <= halted_d;
            retire_cnt_q  <= retire_cnt_d;
        end
    end

    assign cif.updateHead_o     = pop;
    assign cif.rfWriteEn_o      = wr_en;
    assign cif.rfWriteAddr_o    = wr_en ? ent_dest : 5'd0;
    assign cif.rfWriteData_o    = wr_en ? ent_value : 64'd0;
    assign cif.renameClearEn_o  = wr_en;
    assign cif.renameClearTag_o = reset_i ? cif.head_i : '0;

    assign cif.needToRestore_o  = restore_q;
    assign cif.redirectValid_o  = restore_q;
    assign cif.redirectPc_o     = redirect_pc_q;
    assign cif.storeReq_o       = store_req_q;
    assign cif.storeTag_o       = store_tag_q;
    assign cif.halted_o         = halted_q;
    assign cif.retireCount_o    = retire_cnt_q;
endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit; register writes are scored against a queue
// of expected writes filled as entries are presented at the head.
module tb_commit_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int unsigned exp_retire = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;
    wr_t exp_wr[$];

    commit_if #(.ROBsize(16)) bus();

    commit_unit #(.ROBsize(16)) u_dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .cif     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic done, input logic halt, input logic store,
                         input logic misp, input logic regw, input logic [4:0] dest,
                         input logic [63:0] value, input logic [4:0] head);
        logic [4:0] rsv;
        rsv = 5'($urandom);
        bus.commitReadData_i = {rsv, halt, misp, store, regw, dest, done, value};
        bus.head_i           = head;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 5'd0);
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every observed register write must match the oldest expected one.
    always @(negedge clk) begin : rf_monitor
        wr_t e;
        if (rst_n === 1'b1 && bus.rfWriteEn_o === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("rf_unexpected_write", {59'd0, bus.rfWriteAddr_o}, 64'd0);
            end else begin
                e = exp_wr.pop_front();
                chk("rf_addr", {59'd0, bus.rfWriteAddr_o}, {59'd0, e.addr});
                chk("rf_data", bus.rfWriteData_o, e.data);
                chk("rename_clr_en", {63'd0, bus.renameClearEn_o}, 64'd1);
                chk("rename_clr_tag", {59'd0, bus.renameClearTag_o}, {59'd0, bus.head_i});
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.storeAck_i = 1'b0;
        // A done entry during reset must not leak through the combinational outputs.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 64'h77, 5'd1);
        to_neg();
        chk("rst_pop", {63'd0, bus.updateHead_o}, 64'd0);
        chk("rst_rfwe", {63'd0, bus.rfWriteEn_o}, 64'd0);
        chk("rst_store_req", {63'd0, bus.storeReq_o}, 64'd0);
        chk("rst_store_tag", {59'd0, bus.storeTag_o}, 64'd0);
        chk("rst_restore", {63'd0, bus.needToRestore_o}, 64'd0);
        chk("rst_redirect_valid", {63'd0, bus.redirectValid_o}, 64'd0);
        chk("rst_redirect_pc", bus.redirectPc_o, 64'd0);
        chk("rst_halted", {63'd0, bus.halted_o}, 64'd0);
        chk("rst_retire", {32'd0, bus.retireCount_o}, 64'd0);
        to_pos();
        rst_n = 1'b1;

        // Four back-to-back ALU retirements
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 64'(i * 16), 5'(i));
            push_wr(5'(i), 64'(i * 16));
            exp_retire++;
            to_neg();
            chk("alu_pop", {63'd0, bus.updateHead_o}, 64'd1);
            to_pos();
        end
        idle();
        to_neg();
        chk("alu_retire", {32'd0, bus.retireCount_o}, 64'(exp_retire));
        chk("alu_idle_pop", {63'd0, bus.updateHead_o}, 64'd0);
        to_pos();

        // Head not done for three cycles; a stray ack is ignored outside STORE_WAIT
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 64'h55, 5'd5);
            bus.storeAck_i = (i == 1);
            to_neg();
            chk("wait_pop", {63'd0, bus.updateHead_o}, 64'd0);
            chk("wait_rfwe", {63'd0, bus.rfWriteEn_o}, 64'd0);
            chk("wait_store_req", {63'd0, bus.storeReq_o}, 64'd0);
            to_pos();
        end
        bus.storeAck_i = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 64'h55, 5'd5);
        push_wr(5'd5, 64'h55);
        exp_retire++;
        to_neg();
        chk("done_rise_pop", {63'd0, bus.updateHead_o}, 64'd1);
        to_pos();

        // Store at head tag 5, acknowledged in its third STORE_WAIT cycle
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 64'hDEAD, 5'd5);
        to_neg();
        chk("st_head_pop", {63'd0, bus.updateHead_o}, 64'd0);
        chk("st_head_req", {63'd0, bus.storeReq_o}, 64'd0);
        to_pos();
        for (int i = 0; i < 3; i++) begin
            bus.storeAck_i = (i == 2);
            if (i == 2) exp_retire++;
            to_neg();
            chk("st_req", {63'd0, bus.storeReq_o}, 64'd1);
            chk("st_tag", {59'd0, bus.storeTag_o}, 64'd5);
            chk("st_pop", {63'd0, bus.updateHead_o}, (i == 2) ? 64'd1 : 64'd0);
            chk("st_rfwe", {63'd0, bus.rfWriteEn_o}, 64'd0);
            to_pos();
        end
        bus.storeAck_i = 1'b0;
        idle();
        to_neg();
        chk("st_req_drop", {63'd0, bus.storeReq_o}, 64'd0);
        chk("st_retire", {32'd0, bus.retireCount_o}, 64'(exp_retire));
        to_pos();

        // Mispredict: pop and write in N, restore pulse in N+1, commit resumes in N+2
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 64'h1000, 5'd6);
        push_wr(5'd1, 64'h1000);
        exp_retire++;
        to_neg();
        chk("mp_pop", {63'd0, bus.updateHead_o}, 64'd1);
        chk("mp_restore_early", {63'd0, bus.needToRestore_o}, 64'd0);
        to_pos();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 64'hBAD, 5'd7);
        to_neg();
        chk("mp_restore", {63'd0, bus.needToRestore_o}, 64'd1);
        chk("mp_redirect_valid", {63'd0, bus.redirectValid_o}, 64'd1);
        chk("mp_redirect_pc", bus.redirectPc_o, 64'h1000);
        chk("mp_flush_pop", {63'd0, bus.updateHead_o}, 64'd0);
        to_pos();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 64'h33, 5'd7);
        push_wr(5'd3, 64'h33);
        exp_retire++;
        to_neg();
        chk("mp_resume_pop", {63'd0, bus.updateHead_o}, 64'd1);
        chk("mp_restore_drop", {63'd0, bus.needToRestore_o}, 64'd0);
        to_pos();

        // dest 0 with regWrite: retired but no write and no rename clear
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 64'h99, 5'd8);
        exp_retire++;
        to_neg();
        chk("r0_pop", {63'd0, bus.updateHead_o}, 64'd1);
        chk("r0_rfwe", {63'd0, bus.rfWriteEn_o}, 64'd0);
        chk("r0_clr", {63'd0, bus.renameClearEn_o}, 64'd0);
        to_pos();

        // Halt with store and mispredict also set: halt wins
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 64'h4444, 5'd9);
        exp_retire++;
        to_neg();
        chk("halt_pop", {63'd0, bus.updateHead_o}, 64'd1);
        chk("halt_not_yet", {63'd0, bus.halted_o}, 64'd0);
        chk("halt_rfwe", {63'd0, bus.rfWriteEn_o}, 64'd0);
        to_pos();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, (i == 1), 1'b0, 1'b1, 5'd6, 64'h66, 5'd10);
            bus.storeAck_i = 1'b1;
            to_neg();
            chk("halted", {63'd0, bus.halted_o}, 64'd1);
            chk("halted_pop", {63'd0, bus.updateHead_o}, 64'd0);
            chk("halted_store_req", {63'd0, bus.storeReq_o}, 64'd0);
            chk("halted_restore", {63'd0, bus.needToRestore_o}, 64'd0);
            chk("halted_retire", {32'd0, bus.retireCount_o}, 64'(exp_retire));
            to_pos();
        end
        bus.storeAck_i = 1'b0;

        // Reset clears HALTED; then reset asserted mid-STORE_WAIT
        rst_n = 1'b0;
        idle();
        exp_retire = 0;
        to_neg();
        chk("rst2_halted", {63'd0, bus.halted_o}, 64'd0);
        to_pos();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 5'd3);
        to_neg();
        to_pos();
        to_neg();
        chk("rsw_req", {63'd0, bus.storeReq_o}, 64'd1);
        chk("rsw_tag", {59'd0, bus.storeTag_o}, 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rsw_req_drop", {63'd0, bus.storeReq_o}, 64'd0);
        chk("rsw_tag_drop", {59'd0, bus.storeTag_o}, 64'd0);
        chk("rsw_retire", {32'd0, bus.retireCount_o}, 64'd0);
        to_pos();
        rst_n = 1'b1;
        // Back in COMMIT: an ordinary entry retires at once
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 64'h44, 5'd4);
        push_wr(5'd4, 64'h44);
        exp_retire++;
        to_neg();
        chk("rsw_commit_pop", {63'd0, bus.updateHead_o}, 64'd1);
        chk("rsw_commit_req", {63'd0, bus.storeReq_o}, 64'd0);
        to_pos();
        idle();
        to_neg();
        chk("final_retire", {32'd0, bus.retireCount_o}, 64'(exp_retire));
        chk("rf_writes_outstanding", 64'(exp_wr.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
